// File: rtl/mvm_in_seq.sv
// mvm_in_seq: input sequencer in front of the matrix-vector multiply core.
// Collects a frame of matrix/vector words from a gappy valid/ready stream
// into a local buffer, then replays it to the core as a gap-free burst:
// load pulse, contiguous words, start pulse. Input is blocked until done.
module mvm_in_seq #(
    parameter int K = 16,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [B-1:0] s_data,
    input  logic         s_vec_only,
    output logic         load_matrix,
    output logic         load_vector,
    output logic         start,
    output logic [B-1:0] data_out,
    input  logic         mvm_done,
    output logic         busy,
    output logic         err
);

    localparam int MW    = K * K;
    localparam int VW    = K;
    localparam int DEPTH = MW + VW;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LEN_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] LEN_VEC   = CW'(VW);
    localparam logic [CW-1:0] CNT_M_END = CW'(MW);
    localparam logic [CW-1:0] CNT_V_END = CW'(VW);
    localparam logic [AW-1:0] VEC_BASE  = AW'(MW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EMIT_M,
        S_EMIT_V,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           mode_q;
    logic           mat_ok;
    logic           err_q;

    logic [B-1:0]   mem [DEPTH];
    logic [B-1:0]   rd_data;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;

    logic           accept;
    logic           mode_cur;
    logic [CW-1:0]  len_cur;
    logic           fill_last;
    logic           reject;
    logic           word_phase;

    // Accept decode and frame bookkeeping shared by the FSM and datapath
    always_comb begin
        accept    = s_valid & s_ready;
        // Mode is taken from the port on the first word, from the latch after
        mode_cur  = (state == S_IDLE) ? s_vec_only : mode_q;
        len_cur   = mode_cur ? LEN_VEC : LEN_FULL;
        cnt_inc   = cnt + 1'b1;
        fill_last = accept && (cnt_inc == len_cur);
        reject    = fill_last && mode_cur && !mat_ok;
        wr_addr   = mode_cur ? (VEC_BASE + AW'(cnt)) : AW'(cnt);
        rd_addr   = (state == S_EMIT_V) ? (VEC_BASE + AW'(cnt)) : AW'(cnt);
        // Read data lags the address by one cycle, so words appear from cnt=1
        word_phase = ((state == S_EMIT_M) || (state == S_EMIT_V)) && (cnt != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the end-of-fill decision is taken on the last accept
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FILL: begin
                if (fill_last) begin
                    if (!mode_cur) begin
                        state_nxt = S_EMIT_M;
                    end else if (mat_ok) begin
                        state_nxt = S_EMIT_V;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (accept) begin
                    state_nxt = S_FILL;
                end
            end
            S_EMIT_M: begin
                if (cnt == CNT_M_END) begin
                    state_nxt = S_EMIT_V;
                end
            end
            S_EMIT_V: begin
                if (cnt == CNT_V_END) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (mvm_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Word counter, frame mode latch, stored-matrix flag and reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mode_q <= 1'b0;
            mat_ok <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept && (state == S_IDLE)) begin
                mode_q <= s_vec_only;
            end
            if ((state == S_EMIT_M) && (cnt == CNT_M_END)) begin
                mat_ok <= 1'b1;
            end
            case (state)
                S_IDLE, S_FILL: begin
                    if (fill_last) begin
                        cnt <= '0;
                    end else if (accept) begin
                        cnt <= cnt_inc;
                    end
                end
                S_EMIT_M: begin
                    cnt <= (cnt == CNT_M_END) ? '0 : cnt_inc;
                end
                S_EMIT_V: begin
                    cnt <= (cnt == CNT_V_END) ? '0 : cnt_inc;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Frame buffer write port: accepted words stored in arrival order
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= s_data;
        end
    end

    // Frame buffer read port, registered
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

    // Output decode; everything forced low while reset is held
    always_comb begin
        s_ready     = 1'b0;
        busy        = 1'b0;
        load_matrix = 1'b0;
        load_vector = 1'b0;
        start       = 1'b0;
        err         = 1'b0;
        data_out    = '0;
        if (!reset) begin
            s_ready     = (state == S_IDLE) || (state == S_FILL);
            busy        = (state != S_IDLE);
            load_matrix = (state == S_EMIT_M) && (cnt == '0);
            load_vector = (state == S_EMIT_V) && (cnt == '0);
            start       = (state == S_START);
            err         = err_q;
            if (word_phase) begin
                data_out = rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mvm_in_seq.sv
// Testbench for mvm_in_seq: random and directed frames, expected core-side
// traffic scheduled into a queue by a frame-level model, checked per cycle.
module tb_mvm_in_seq;

    localparam int K      = 16;
    localparam int B      = 8;
    localparam int KK     = K * K;
    localparam int N_FULL = KK + K;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [B-1:0] s_data = '0;
    logic         s_vec_only = 1'b0;
    logic         load_matrix;
    logic         load_vector;
    logic         start;
    logic [B-1:0] data_out;
    logic         mvm_done = 1'b0;
    logic         busy;
    logic         err;

    typedef struct {
        int         cyc;
        logic       lm;
        logic       lv;
        logic       st;
        logic       er;
        logic [7:0] d;
    } exp_t;

    exp_t       expq[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         mat_ok_m = 1'b0;
    logic [7:0] fw[N_FULL];

    mvm_in_seq #(.K(K), .B(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_vec_only (s_vec_only),
        .load_matrix(load_matrix),
        .load_vector(load_vector),
        .start      (start),
        .data_out   (data_out),
        .mvm_done   (mvm_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_e(input int c, input bit lm, input bit lv,
                                   input bit st, input bit er, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.lm = lm; e.lv = lv; e.st = st; e.er = er; e.d = d;
        expq.push_back(e);
    endfunction

    // Frame-level model: given the cycle of the last accept, schedule the
    // core-side traffic. Returns the start-pulse cycle, or -1 if rejected.
    function automatic int push_frame(input bit vec, input int last);
        int base;
        int voff;
        if (!vec) begin
            push_e(last + 1, 1, 0, 0, 0, 8'h00);
            for (int i = 0; i < KK; i++) push_e(last + 2 + i, 0, 0, 0, 0, fw[i]);
            base = last + KK + 2;
            voff = KK;
            mat_ok_m = 1'b1;
        end else if (mat_ok_m) begin
            base = last + 1;
            voff = 0;
        end else begin
            push_e(last + 1, 0, 0, 0, 1, 8'h00);
            return -1;
        end
        push_e(base, 0, 1, 0, 0, 8'h00);
        for (int j = 0; j < K; j++) push_e(base + 1 + j, 0, 0, 0, 0, fw[voff + j]);
        push_e(base + K + 1, 0, 0, 1, 0, 8'h00);
        return base + K + 1;
    endfunction

    // Monitor: every cycle, compare core-side outputs with the schedule
    always @(negedge clk) begin
        logic [11:0] act;
        exp_t        e;
        act = {load_matrix, load_vector, start, err, data_out};
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            chk($sformatf("stale_exp_c%0d", expq[0].cyc), cyc, expq[0].cyc);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            chk($sformatf("out_c%0d", cyc), int'(act), int'({e.lm, e.lv, e.st, e.er, e.d}));
        end else begin
            chk($sformatf("idle_c%0d", cyc), int'(act), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit vec, input int gap_mode,
                              output int last, output int start_cyc);
        int  n;
        bit  ok;
        bit  accepted;
        int  tries;
        n    = vec ? K : N_FULL;
        ok   = 1'b1;
        last = -1;
        for (int i = 0; i < n && ok; i++) begin
            if (gap_mode == 1 && i > 0) begin
                s_valid = 1'b0;
                tick();
            end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid    = 1'b1;
            s_data     = fw[i];
            s_vec_only = (i == 0) ? vec : 1'($urandom);
            accepted   = 1'b0;
            tries      = 0;
            while (!accepted && tries < 64) begin
                @(negedge clk);
                if (s_ready) begin
                    accepted = 1'b1;
                    last     = cyc;
                end
                tick();
                tries++;
            end
            if (!accepted) begin
                chk("accept_timeout", 0, 1);
                ok = 1'b0;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            start_cyc = -1;
            return;
        end
        start_cyc = push_frame(vec, last);
        @(negedge clk);
        chk("s_ready_after_last", s_ready, start_cyc < 0);
        chk("busy_after_last", busy, start_cyc >= 0);
        tick();
    endtask

    task automatic do_done(input int s, input bit hold);
        int nwait;
        while (cyc < s + 1) tick();
        nwait = $urandom_range(1, 4);
        for (int k = 0; k < nwait; k++) begin
            s_valid = hold;
            s_data  = 8'($urandom);
            @(negedge clk);
            chk("s_ready_wait_done", s_ready, 0);
            chk("busy_wait_done", busy, 1);
            tick();
        end
        mvm_done = 1'b1;
        @(negedge clk);
        chk("s_ready_done_cycle", s_ready, 0);
        tick();
        mvm_done = 1'b0;
        s_valid  = 1'b0;
        @(negedge clk);
        chk("s_ready_after_done", s_ready, 1);
        chk("busy_after_done", busy, 0);
        tick();
    endtask

    initial begin
        int last;
        int s;
        int r_cyc;
        bit vec;

        // Reset
        repeat (3) begin
            @(negedge clk);
            chk("s_ready_in_reset", s_ready, 0);
            chk("busy_in_reset", busy, 0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1);
        chk("busy_after_reset", busy, 0);
        tick();

        // Vector-only frame with no stored matrix: rejected
        for (int i = 0; i < N_FULL; i++) fw[i] = 8'($urandom);
        send_frame(1'b1, 0, last, s);

        // Full frame, index pattern, no gaps
        for (int i = 0; i < N_FULL; i++) fw[i] = 8'(i);
        send_frame(1'b0, 0, last, s);
        if (s >= 0) do_done(s, 1'b0);

        // Same frame with s_valid toggling, input held during wait for done
        send_frame(1'b0, 1, last, s);
        if (s >= 0) do_done(s, 1'b1);

        // Spurious done in IDLE
        mvm_done = 1'b1;
        @(negedge clk);
        chk("s_ready_spurious_done", s_ready, 1);
        chk("busy_spurious_done", busy, 0);
        tick();
        mvm_done = 1'b0;
        @(negedge clk);
        chk("s_ready_after_spurious", s_ready, 1);
        chk("busy_after_spurious", busy, 0);
        tick();

        // Vector-only frame reusing stored matrix
        for (int j = 0; j < K; j++) fw[j] = 8'(8'h80 + j);
        send_frame(1'b1, 0, last, s);
        if (s >= 0) do_done(s, 1'b0);

        // Random frames with random gaps
        for (int r = 0; r < 5; r++) begin
            vec = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_FULL; i++) fw[i] = 8'($urandom);
            send_frame(vec, 2, last, s);
            if (s >= 0) do_done(s, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset at the 100th emitted matrix word
        for (int i = 0; i < N_FULL; i++) fw[i] = 8'($urandom);
        send_frame(1'b0, 0, last, s);
        r_cyc = last + 101;
        while (cyc < r_cyc) tick();
        reset = 1'b1;
        while (expq.size() > 0 && expq[$].cyc >= r_cyc) void'(expq.pop_back());
        mat_ok_m = 1'b0;
        @(negedge clk);
        chk("s_ready_mid_reset", s_ready, 0);
        chk("busy_mid_reset", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("s_ready_after_mid_reset", s_ready, 1);
        tick();

        // Stored matrix lost with reset: vector-only frame rejected
        for (int i = 0; i < N_FULL; i++) fw[i] = 8'($urandom);
        send_frame(1'b1, 0, last, s);

        repeat (5) tick();
        chk("exp_queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_in_seq.md
# mvm_in_seq

Input sequencer that sits directly upstream of the matrix-vector multiply core. It accepts matrix and vector words over a valid/ready stream that may contain gaps, and stages a complete frame in a local buffer. It then replays the frame to the core as the gap-free burst protocol the core requires: load pulse, contiguous words, start pulse. It blocks new input until the core reports done.

## Interface
- K, 16, matrix dimension (matrix K*K words, vector K words)
- B, 8, word width in bits
- clk  in  1  clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- s_valid  in  1  upstream word valid
- s_ready  out  1  block accepts word when s_valid & s_ready
- s_data  in  B  upstream word, signed
- s_vec_only  in  1  frame type, sampled on first word of frame: 0 = matrix then vector, 1 = vector only (reuse stored matrix)
- load_matrix  out  1  one-cycle pulse to core
- load_vector  out  1  one-cycle pulse to core
- start  out  1  one-cycle pulse to core
- data_out  out  B  word to core data_in
- mvm_done  in  1  one-cycle done pulse from core
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse: vector-only frame rejected

## Operation
- Buffer: K*K+K words. Matrix region is addr 0..K*K-1; vector region is K*K..K*K+K-1. Synchronous write and synchronous read.
- Flag mat_ok: cleared by reset, set when a full frame is emitted. It is never cleared by a vector-only frame.
- States and transitions:
  - IDLE: s_ready=1. First accepted word latches mode from s_vec_only, stores the word, count=1, then goes to FILL. If N=1, it goes straight to the end-of-fill decision.
  - FILL: s_ready=1. Each accepted word is stored in order and count increments. Frame length N is K*K+K (mode 0) or K (mode 1); vector-only words go to the vector region. The cycle after the N-th accept:
    - mode 0 → EMIT_M.
    - mode 1 with mat_ok → EMIT_V.
    - mode 1 with !mat_ok → err pulse, back to IDLE. The frame is discarded and nothing is issued to the core.
  - EMIT_M: load_matrix pulse in the first cycle, then K*K matrix words on consecutive cycles, then → EMIT_V.
  - EMIT_V: load_vector pulse, then K vector words consecutively, then → START.
  - START: start pulse for one cycle, then → WAIT_DONE.
  - WAIT_DONE: s_ready=0. On mvm_done → IDLE.
- s_ready = (state is IDLE or FILL) & !reset, decoded combinationally from state.
- data_out is 0 in every cycle that does not carry an emitted word. Words pass unmodified; there is no arithmetic.
- mvm_done is ignored in every state except WAIT_DONE.
- The stored matrix persists across frames. A vector-only frame overwrites only the vector region.

## Timing
- Reset: state IDLE, count 0, mat_ok 0. During reset, load_matrix, load_vector, start, err and busy are 0, data_out is 0 and s_ready is 0. s_ready is 1 in the first cycle after reset deasserts. Buffer contents are undefined.
- Reset mid-operation at any state aborts immediately. The next cycle shows reset values; no further pulses or words are issued.
- Full frame: last word accepted in cycle L.
  - load_matrix at T=L+1.
  - Matrix word i on data_out at T+1+i, for i=0..K*K-1.
  - load_vector at T+K*K+1.
  - Vector word j at T+K*K+2+j.
  - start at T+K*K+K+2.
- Vector-only: last accept in cycle L. load_vector at L+1, word j at L+2+j, start at L+K+2.
- mvm_done in cycle D → state IDLE in D+1, s_ready=1 in D+1.
- Gaps on s_valid stretch FILL only. Emitted bursts are always gap-free.
- busy is 1 from the cycle after the first accept through cycle D. It is 0 in the err cycle.

## Test plan
- K=16. Full frame of 272 words, s_data = index mod 256, no gaps → load_matrix at L+1, data_out = 0..255 at L+2..L+257, load_vector at L+258, data_out = 0..15 at L+259..L+274, start at L+275.
- Same frame with s_valid toggling every other cycle → identical gap-free output sequence relative to the last accept.
- After a full frame and mvm_done, a vector-only frame of 0x80..0x8F → no load_matrix; load_vector at L+1; data_out = 0x80..0x8F at L+2..L+17; start at L+18.
- Vector-only frame directly after reset → err pulse at L+1; load_vector, load_matrix and start never assert; s_ready=1 at L+1.
- Backpressure and spurious done: s_valid held high through WAIT_DONE → s_ready=0 until D+1; mvm_done pulsed in IDLE → no state change.
- Reset asserted at the 100th emitted matrix word → data_out=0 and no pulses afterward; a following vector-only frame produces err.
